// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle of the data cache controller.
// slave: controller view; master: pipeline/memory view. Stats ports under DCACHE_STATS_EN.
interface dcache_controller_if;
  logic         MemRead_i;
  logic         MemWrite_i;
  logic [31:0]  addr_i;
  logic [31:0]  wdata_i;
  logic [31:0]  rdata_o;
  logic         stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count_o;
  logic [31:0]  miss_count_o;

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output rdata_o, stall_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o,
    output hit_count_o, miss_count_o
  );

  modport master (
    output MemRead_i, MemWrite_i, addr_i, wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  rdata_o, stall_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o,
    input  hit_count_o, miss_count_o
  );
`else
  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output rdata_o, stall_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output MemRead_i, MemWrite_i, addr_i, wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  rdata_o, stall_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
`endif
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache, 32 x 256-bit lines, IDLE/WRITEBACK/ALLOCATE FSM.
// Ports: clk_i, rst_i (async, active low), bus (dcache_controller_if.slave); DCACHE_STATS_EN adds counters.
module dcache_controller (
  input logic              clk_i,
  input logic              rst_i,
  dcache_controller_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0]   state;
  logic [31:5]  lat_addr;
  logic [31:0]  valid;
  logic [31:0]  dirty;
  logic [21:0]  tag_q  [32];
  logic [255:0] data_q [32];

  logic         req;
  logic [4:0]   idx;
  logic [2:0]   word;
  logic [21:0]  tag;
  logic [4:0]   l_idx;
  logic         hit;
  logic         miss;
  logic         ack;

  assign req   = bus.MemRead_i | bus.MemWrite_i;
  assign idx   = bus.addr_i[9:5];
  assign word  = bus.addr_i[4:2];
  assign tag   = bus.addr_i[31:10];
  assign l_idx = lat_addr[9:5];
  assign hit   = req & valid[idx] & (tag_q[idx] == tag);
  assign miss  = (state == IDLE) & req & ~hit;
  assign ack   = bus.mem_ack_i;

  // Outputs are forced to zero while reset is held, even with a request pending.
  always_comb begin
    bus.stall_o      = 1'b0;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_wdata_o  = '0;
    bus.rdata_o      = '0;
    if (rst_i) begin
      bus.rdata_o = data_q[idx][{word, 5'b0} +: 32];
      unique case (state)
        IDLE: bus.stall_o = miss;
        WRITEBACK: begin
          bus.stall_o      = 1'b1;
          bus.mem_enable_o = 1'b1;
          bus.mem_write_o  = 1'b1;
          bus.mem_addr_o   = {tag_q[l_idx], l_idx, 5'b0};
          bus.mem_wdata_o  = data_q[l_idx];
        end
        ALLOCATE: begin
          bus.stall_o      = 1'b1;
          bus.mem_enable_o = 1'b1;
          bus.mem_addr_o   = {lat_addr[31:10], l_idx, 5'b0};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      lat_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss) begin
            lat_addr <= bus.addr_i[31:5];
            state    <= (valid[idx] & dirty[idx]) ? WRITEBACK : ALLOCATE;
          end else if (bus.MemWrite_i & hit) begin
            dirty[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (ack) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (ack) begin
            valid[l_idx] <= 1'b1;
            dirty[l_idx] <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays are not reset; valid bits guard their use.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && bus.MemWrite_i && hit)
      data_q[idx][{word, 5'b0} +: 32] <= bus.wdata_i;
    if (state == ALLOCATE && ack) begin
      data_q[l_idx] <= bus.mem_rdata_i;
      tag_q[l_idx]  <= lat_addr[31:10];
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  // refill marks the cycle that completes a missed access, which is not a hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      refill   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      refill <= (state == ALLOCATE) & ack;
      if (state == IDLE && hit && !refill)
        hit_cnt <= hit_cnt + 32'd1;
      if (miss)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.hit_count_o  = hit_cnt;
  assign bus.miss_count_o = miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: memory model, read scoreboard,
// miss/hit/writeback/reset-abort/delayed-ack scenarios (stats under DCACHE_STATS_EN).
module tb_dcache_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;

  logic [255:0] tb_mem [bit [31:0]];
  logic [31:0]  cpu_view [bit [31:0]];
  logic [31:0]  sb [$];

  dcache_controller_if bus ();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] view(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return cpu_view.exists(wa) ? cpu_view[wa] : 32'h0;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : 256'h0;
  endfunction

  task automatic access(
    input  bit           wr,
    input  logic [31:0]  a,
    input  logic [31:0]  d,
    input  int           lat,
    output int           stalls,
    output int           nen,
    output int           nwb,
    output logic [31:0]  wb_addr,
    output logic [255:0] wb_data,
    output int           nal,
    output logic [31:0]  al_addr
  );
    int cnt;
    bit done;
    logic [31:0] raddr;
    logic [31:0] exp;
    stalls = 0; nen = 0; nwb = 0; nal = 0;
    wb_addr = '0; wb_data = '0; al_addr = '0;
    cnt = 0; done = 0; raddr = '0;
    bus.MemRead_i  = ~wr;
    bus.MemWrite_i = wr;
    bus.addr_i     = a;
    bus.wdata_i    = d;
    if (!wr) sb.push_back(view(a));
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      if (!bus.stall_o) begin
        if (!wr) begin
          exp = sb.pop_front();
          checks++;
          if (bus.rdata_o !== exp) begin
            fails++;
            $display("FAIL load_data addr=%h got=%h exp=%h", a, bus.rdata_o, exp);
          end
        end
        done = 1;
      end else begin
        stalls++;
        if (bus.mem_enable_o) begin
          nen++;
          if (cnt == 0) raddr = bus.mem_addr_o;
          else begin
            checks++;
            if (bus.mem_addr_o !== raddr) begin
              fails++;
              $display("FAIL addr_stable got=%h exp=%h", bus.mem_addr_o, raddr);
            end
          end
          cnt++;
          if (cnt == lat) begin
            if (bus.mem_write_o) begin
              nwb++;
              wb_addr = bus.mem_addr_o;
              wb_data = bus.mem_wdata_o;
              tb_mem[bus.mem_addr_o] = bus.mem_wdata_o;
            end else begin
              nal++;
              al_addr = bus.mem_addr_o;
              bus.mem_rdata_i = mem_line(bus.mem_addr_o);
            end
            bus.mem_ack_i = 1'b1;
            @(posedge clk);
            #1 bus.mem_ack_i = 1'b0;
            cnt = 0;
          end
        end
      end
    end
    if (!done) begin
      fails++;
      $display("FAIL access_timeout addr=%h got=stalled exp=complete", a);
    end
    @(posedge clk);
    #1;
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
    if (wr) cpu_view[{a[31:2], 2'b00}] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.MemRead_i = 1'b1;
    bus.addr_i = 32'h40;
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL rst_stall got=%b exp=0", bus.stall_o); end
    checks++; if (bus.mem_enable_o !== 1'b0) begin fails++; $display("FAIL rst_en got=%b exp=0", bus.mem_enable_o); end
    checks++; if (bus.mem_write_o !== 1'b0) begin fails++; $display("FAIL rst_wr got=%b exp=0", bus.mem_write_o); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin fails++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin fails++; $display("FAIL rst_rdata got=%h exp=0", bus.rdata_o); end
    bus.MemRead_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_read_miss();
    int st, ne, nw, na;
    logic [31:0] wa, aa;
    logic [255:0] wd, line;
    line = '0;
    line[95:64] = 32'hDEADBEEF;
    tb_mem[32'h40] = line;
    cpu_view[32'h48] = 32'hDEADBEEF;
    access(0, 32'h40, 0, 2, st, ne, nw, wa, wd, na, aa);
    checks++; if (st != 3) begin fails++; $display("FAIL miss_stalls got=%0d exp=3", st); end
    checks++; if (nw != 0 || na != 1) begin fails++; $display("FAIL miss_kind got=wb%0d/al%0d exp=wb0/al1", nw, na); end
    checks++; if (aa !== 32'h40) begin fails++; $display("FAIL alloc_addr got=%h exp=00000040", aa); end
    access(0, 32'h48, 0, 2, st, ne, nw, wa, wd, na, aa);
    checks++; if (st != 0) begin fails++; $display("FAIL hit_stall got=%0d exp=0", st); end
  endtask

  task automatic test_write_hit();
    int st, ne, nw, na;
    logic [31:0] wa, aa;
    logic [255:0] wd;
    access(1, 32'h48, 32'h12345678, 2, st, ne, nw, wa, wd, na, aa);
    checks++; if (st != 0) begin fails++; $display("FAIL store_stall got=%0d exp=0", st); end
    access(0, 32'h48, 0, 2, st, ne, nw, wa, wd, na, aa);
    checks++; if (st != 0) begin fails++; $display("FAIL reload_stall got=%0d exp=0", st); end
  endtask

  task automatic test_writeback();
    int st, ne, nw, na;
    logic [31:0] wa, aa;
    logic [255:0] wd, line;
    line = '0;
    line[31:0] = 32'hCAFEF00D;
    tb_mem[32'h440] = line;
    cpu_view[32'h440] = 32'hCAFEF00D;
    access(0, 32'h440, 0, 3, st, ne, nw, wa, wd, na, aa);
    checks++; if (nw != 1) begin fails++; $display("FAIL wb_count got=%0d exp=1", nw); end
    checks++; if (wa !== 32'h40) begin fails++; $display("FAIL wb_addr got=%h exp=00000040", wa); end
    checks++; if (wd[95:64] !== 32'h12345678) begin fails++; $display("FAIL wb_data got=%h exp=12345678", wd[95:64]); end
    checks++; if (na != 1 || aa !== 32'h440) begin fails++; $display("FAIL wb_alloc got=%0d/%h exp=1/00000440", na, aa); end
  endtask

  task automatic test_delayed_ack();
    int st, ne, nw, na;
    logic [31:0] wa, aa;
    logic [255:0] wd;
    access(0, 32'h48, 0, 10, st, ne, nw, wa, wd, na, aa);
    checks++; if (st != 11) begin fails++; $display("FAIL slow_stalls got=%0d exp=11", st); end
    checks++; if (ne != 10) begin fails++; $display("FAIL slow_enable got=%0d exp=10", ne); end
    checks++; if (nw != 0 || aa !== 32'h40) begin fails++; $display("FAIL slow_alloc got=wb%0d/%h exp=wb0/00000040", nw, aa); end
  endtask

  task automatic test_reset_abort();
    int st, ne, nw, na;
    logic [31:0] wa, aa;
    logic [255:0] wd;
    bit seen;
    seen = 0;
    bus.MemRead_i = 1'b1;
    bus.addr_i = 32'h200;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_enable_o;
    end
    checks++; if (!seen) begin fails++; $display("FAIL abort_start got=idle exp=allocate"); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.stall_o !== 1'b0 || bus.mem_enable_o !== 1'b0) begin
      fails++; $display("FAIL abort_rst got=%b%b exp=00", bus.stall_o, bus.mem_enable_o);
    end
    checks++; if (bus.mem_addr_o !== 32'h0) begin fails++; $display("FAIL abort_addr got=%h exp=0", bus.mem_addr_o); end
    bus.MemRead_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rdata_i = '1;
    bus.mem_ack_i = 1'b1;
    @(posedge clk);
    #1 bus.mem_ack_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_enable_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      fails++; $display("FAIL stray_ack got=%b%b exp=00", bus.mem_enable_o, bus.stall_o);
    end
    access(0, 32'h48, 0, 2, st, ne, nw, wa, wd, na, aa);
    checks++; if (na != 1) begin fails++; $display("FAIL post_rst_miss got=%0d exp=1", na); end
    access(0, 32'h200, 0, 2, st, ne, nw, wa, wd, na, aa);
    checks++; if (na != 1) begin fails++; $display("FAIL stray_not_filled got=%0d exp=1", na); end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    int st, ne, nw, na;
    logic [31:0] wa, aa;
    logic [255:0] wd;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    access(0, 32'h100, 0, 2, st, ne, nw, wa, wd, na, aa);
    access(0, 32'h100, 0, 2, st, ne, nw, wa, wd, na, aa);
    access(0, 32'h104, 0, 2, st, ne, nw, wa, wd, na, aa);
    access(0, 32'h108, 0, 2, st, ne, nw, wa, wd, na, aa);
    @(negedge clk);
    checks++; if (bus.miss_count_o !== 32'd1) begin fails++; $display("FAIL miss_count got=%0d exp=1", bus.miss_count_o); end
    checks++; if (bus.hit_count_o !== 32'd3) begin fails++; $display("FAIL hit_count got=%0d exp=3", bus.hit_count_o); end
  endtask
`endif

  initial begin
    bus.MemRead_i   = 1'b0;
    bus.MemWrite_i  = 1'b0;
    bus.addr_i      = '0;
    bus.wdata_i     = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;
    test_reset();
    test_read_miss();
    test_write_hit();
    test_writeback();
    test_delayed_ack();
    test_reset_abort();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 clk_i  input  1  clock, all state updates on rising edge.
REQ-002 rst_i  input  1  asynchronous, active-low reset.
REQ-003 MemRead_i  input  1  load request from EX/MEM latch.
REQ-004 MemWrite_i  input  1  store request from EX/MEM latch.
REQ-005 addr_i  input  32  byte address (ALU result).
REQ-006 wdata_i  input  32  store data (RS2 data).
REQ-007 rdata_o  output  32  load data, valid when MemRead_i=1 and stall_o=0.
REQ-008 stall_o  output  1  pipeline freeze, drives stall_i of all pipeline latches.
REQ-009 mem_enable_o  output  1  memory request, held until mem_ack_i.
REQ-010 mem_write_o  output  1  1 = write-back, 0 = line fetch.
REQ-011 mem_addr_o  output  32  line-aligned memory address, bits [4:0]=0.
REQ-012 mem_wdata_o  output  256  victim line data.
REQ-013 mem_rdata_i  input  256  fetched line, valid in the mem_ack_i cycle.
REQ-014 mem_ack_i  input  1  one-cycle completion pulse from memory.

Function
REQ-015 Organisation SHALL be direct-mapped, 32 lines x 256 bits: offset=addr_i[4:0], word select=addr_i[4:2], index=addr_i[9:5], tag=addr_i[31:10]; addr_i[1:0] ignored.
REQ-016 Per line: valid bit, dirty bit, 22-bit tag, 256-bit data, all internal.
REQ-017 req = MemRead_i|MemWrite_i; hit = req & valid[index] & (tag[index]==addr_i[31:10]).
REQ-018 stall_o SHALL be combinational: 1 when req & ~hit in IDLE, 1 in WRITEBACK and ALLOCATE, else 0.
REQ-019 Read hit: zero added latency; rdata_o = selected word, combinational.
REQ-020 Write hit: selected word updated and dirty set on the rising edge; no stall.
REQ-021 MemRead_i and MemWrite_i both 1: treated as a write.
REQ-022 FSM states: IDLE, WRITEBACK, ALLOCATE.
REQ-023 IDLE -> WRITEBACK on miss with victim valid & dirty; IDLE -> ALLOCATE on miss otherwise; miss address latched on the transition.
REQ-024 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,index,5'b0}, mem_wdata_o=victim line; on mem_ack_i -> ALLOCATE.
REQ-025 ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={latched tag,index,5'b0}; on mem_ack_i write mem_rdata_i, tag, valid=1, dirty=0, -> IDLE.
REQ-026 Back in IDLE the access hits and completes per REQ-019/020 in that cycle (total miss penalty = memory latency + 1 cycle per transaction).
REQ-027 mem_ack_i SHALL be ignored in IDLE; mem_enable_o=0 and mem_write_o=0 in IDLE.
REQ-028 Request inputs held stable while stall_o=1; controller uses the latched address during WRITEBACK/ALLOCATE.

Reset
REQ-029 rst_i=0 SHALL immediately force state IDLE, clear all valid and dirty bits, drive stall_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, rdata_o=0.
REQ-030 Reset during WRITEBACK/ALLOCATE SHALL abandon the transaction; a later mem_ack_i is ignored.
REQ-031 Tag and data arrays need not be reset.

Configuration
REQ-032 Macro DCACHE_STATS_EN defined: adds outputs hit_count_o[31:0] and miss_count_o[31:0], incremented once per completed hit and once per IDLE->miss transition, wrapping 32'hFFFFFFFF -> 0, reset to 0; the post-refill hit SHALL NOT count as a hit.
REQ-033 Macro undefined: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-034 After reset, load 0x0000_0040 -> stall_o=1, ALLOCATE, mem_addr_o=0x0000_0040; ack with line word2=0xDEADBEEF at load 0x48 -> rdata_o=0xDEADBEEF, stall_o=0.
REQ-035 Store 0x12345678 to 0x48 (hit) -> no stall; subsequent load 0x48 -> 0x12345678 with no stall.
REQ-036 Dirty line at index 2, load 0x0000_0440 -> WRITEBACK mem_addr_o=0x0000_0040, mem_wdata_o containing 0x12345678, then ALLOCATE mem_addr_o=0x0000_0440.
REQ-037 rst_i pulsed low during ALLOCATE, then stray mem_ack_i -> state IDLE, mem_enable_o=0, next load to same address misses.
REQ-038 Memory ack delayed 10 cycles -> stall_o high all 10 cycles, mem_enable_o held, addr stable.
REQ-039 With DCACHE_STATS_EN: miss, refill, 3 hits -> miss_count_o=1, hit_count_o=3.
